// File: rtl/mdu_pkg.sv
// Shared MDU definitions: operation encodings, FSM state type and default latencies.
// The MADD/MADDU/MSUB/MSUBU family is only classed as a long operation when MDU_MADD_EN is defined.
package mdu_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  typedef enum logic {IDLE, BUSY} state_e;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Operations that occupy the unit for a multi-cycle latency.
  function automatic logic is_long_op(input logic [3:0] op);
    logic r;
    r = (op == OP_MULT) || (op == OP_MULTU) || is_div_op(op);
`ifdef MDU_MADD_EN
    r = r || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    return r;
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Request/result bundle between an issuing core and the MDU.
interface mdu_ctrl_if;
  logic        Start;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, MDUOp, A, B, input Busy, HI, LO);
  modport slave  (input Start, MDUOp, A, B, output Busy, HI, LO);
endinterface

// File: rtl/mdu_calc.sv
// Combinational 64-bit result {HI,LO} for the latched operation.
// Accumulator input and multiply-accumulate ops exist only with MDU_MADD_EN.
module mdu_calc
  import mdu_pkg::*;
(
`ifdef MDU_MADD_EN
  input  logic [63:0] acc,
`endif
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] res
);

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, b_safe, b_mag_safe;
  logic [31:0] uq, ur, sq_mag, sr_mag, sq, sr;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'b0, a} * {32'b0, b};

  // Signed divide via magnitudes so INT_MIN / -1 wraps to INT_MIN without overflow.
  assign a_mag      = a[31] ? -a : a;
  assign b_mag      = b[31] ? -b : b;
  assign b_safe     = (b == 32'd0) ? 32'd1 : b;
  assign b_mag_safe = (b == 32'd0) ? 32'd1 : b_mag;
  assign uq         = a / b_safe;
  assign ur         = a % b_safe;
  assign sq_mag     = a_mag / b_mag_safe;
  assign sr_mag     = a_mag % b_mag_safe;
  assign sq         = (a[31] ^ b[31]) ? -sq_mag : sq_mag;
  assign sr         = a[31] ? -sr_mag : sr_mag;

  always_comb begin
    res = 64'd0;
    case (op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV:   res = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {sr, sq};
      OP_DIVU:  res = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {ur, uq};
`ifdef MDU_MADD_EN
      OP_MADD:  res = acc + prod_s;
      OP_MADDU: res = acc + prod_u;
      OP_MSUB:  res = acc - prod_s;
      OP_MSUBU: res = acc - prod_u;
`endif
      default:  res = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit controller: IDLE/BUSY FSM, latency counter and HI/LO.
// Optional MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU with multiply latency.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  mdu_ctrl_if.slave bus
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  state_e           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       op_reg;
  logic [31:0]      a_reg, b_reg, hi_reg, lo_reg;
  logic             armed_reg;
  logic [63:0]      res;

  mdu_calc u_calc (
`ifdef MDU_MADD_EN
    .acc (({hi_reg, lo_reg})),
`endif
    .op  (op_reg),
    .a   (a_reg),
    .b   (b_reg),
    .res (res)
  );

  // armed_reg blocks a Start on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= OP_NOP;
      a_reg     <= '0;
      b_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      armed_reg <= 1'b0;
    end else begin
      armed_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (bus.Start && armed_reg) begin
            if (is_long_op(bus.MDUOp)) begin
              op_reg    <= bus.MDUOp;
              a_reg     <= bus.A;
              b_reg     <= bus.B;
              cnt_reg   <= is_div_op(bus.MDUOp) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
              state_reg <= BUSY;
            end else if (bus.MDUOp == OP_MTHI) begin
              hi_reg <= bus.A;
            end else if (bus.MDUOp == OP_MTLO) begin
              lo_reg <= bus.A;
            end
          end
        end
        BUSY: begin
          if (cnt_reg == CNT_W'(1)) begin
            {hi_reg, lo_reg} <= res;
            cnt_reg          <= '0;
            state_reg        <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.Busy = (state_reg == BUSY);
  assign bus.HI   = hi_reg;
  assign bus.LO   = lo_reg;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases, busy/reset scenarios and randomized ops
// against an arithmetic reference model. Honours MDU_MADD_EN for the accumulate ops.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int ML = 5;
  localparam int DL = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdu_ctrl_if bus ();

  mdu_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  // Reference: architectural effect of one op on HI/LO and its Busy latency.
  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lat = 0;
    case (op)
      OP_MULT:  begin p = sa * sb; {m_hi, m_lo} = p; lat = ML; end
      OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; lat = ML; end
      OP_DIV: begin
        lat = DL;
        if (b == 0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
        else begin sq = sa / sb; sr = sa % sb; m_lo = sq[31:0]; m_hi = sr[31:0]; end
      end
      OP_DIVU: begin
        lat = DL;
        if (b == 0) begin m_hi = a; m_lo = 32'hFFFF_FFFF; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
`ifdef MDU_MADD_EN
      OP_MADD:  begin {m_hi, m_lo} = {m_hi, m_lo} + 64'(sa * sb); lat = ML; end
      OP_MADDU: begin {m_hi, m_lo} = {m_hi, m_lo} + {32'b0, a} * {32'b0, b}; lat = ML; end
      OP_MSUB:  begin {m_hi, m_lo} = {m_hi, m_lo} - 64'(sa * sb); lat = ML; end
      OP_MSUBU: begin {m_hi, m_lo} = {m_hi, m_lo} - {32'b0, a} * {32'b0, b}; lat = ML; end
`endif
      default: ;
    endcase
  endtask

  // Issue one request and count Busy cycles (bounded); outputs sampled on negedges.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int nbusy);
    @(negedge clk);
    bus.Start = 1'b1; bus.MDUOp = op; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.Start = 1'b0;
    nbusy = 0;
    while (bus.Busy === 1'b1 && nbusy < 100) begin
      nbusy++;
      @(negedge clk);
    end
    $display("op=%0d a=%h b=%h busy=%0d hi=%h lo=%h", op, a, b, nbusy, bus.HI, bus.LO);
  endtask

  task automatic test_reset();
    bus.Start = 1'b1; bus.MDUOp = OP_MTHI; bus.A = 32'hDEAD_BEEF; bus.B = 32'd0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.Busy, bus.HI, bus.LO} !== {1'b0, 64'd0}) begin
      $display("FAIL reset_state: busy=%b hi=%h lo=%h want 0/0/0", bus.Busy, bus.HI, bus.LO);
      n_bad++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    n_cmp++;
    if (bus.HI !== 32'd0) begin
      $display("FAIL start_on_release: hi=%h want 00000000", bus.HI);
      n_bad++;
    end
  endtask

  task automatic test_directed();
    logic [3:0]  t_op[9];
    logic [31:0] t_a[9], t_b[9], t_hi[9], t_lo[9];
    int          t_lat[9];
    int nb, lat;
    t_op  = '{OP_MULT, OP_DIVU, OP_DIV, OP_DIVU, OP_DIV, OP_DIV, OP_NOP, 4'hF, OP_MTHI};
    t_a   = '{32'hFFFF_FFFD, 32'd100, 32'hFFFF_FFF9, 32'd5, 32'h8000_0000, 32'hFFFF_FFF0,
              32'd1, 32'd2, 32'hCAFE_0001};
    t_b   = '{32'd7, 32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd3, 32'd4, 32'd0};
    t_hi  = '{32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'd0, 32'hFFFF_FFF0,
              32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hCAFE_0001};
    t_lo  = '{32'hFFFF_FFEB, 32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000,
              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    t_lat = '{ML, DL, DL, DL, DL, DL, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      model_op(t_op[i], t_a[i], t_b[i], lat);
      run_op(t_op[i], t_a[i], t_b[i], nb);
      n_cmp++;
      if ({nb, bus.HI, bus.LO} !== {t_lat[i], t_hi[i], t_lo[i]}) begin
        $display("FAIL directed_%0d: busy=%0d hi=%h lo=%h want busy=%0d hi=%h lo=%h",
                 i, nb, bus.HI, bus.LO, t_lat[i], t_hi[i], t_lo[i]);
        n_bad++;
      end
    end
  endtask

  task automatic test_busy_ignore();
    int nb, lat;
    logic [31:0] a, b;
    a = 32'h1234_5678; b = 32'h9ABC_DEF1;
    model_op(OP_MULTU, a, b, lat);
    @(negedge clk);
    bus.Start = 1'b1; bus.MDUOp = OP_MULTU; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.Start = 1'b0;
    nb = 0;
    while (bus.Busy === 1'b1 && nb < 100) begin
      nb++;
      if (nb == 2) begin
        bus.Start = 1'b1; bus.MDUOp = OP_MTLO; bus.A = 32'd1234;
      end else begin
        bus.Start = 1'b0;
      end
      @(negedge clk);
    end
    bus.Start = 1'b0;
    $display("op=%0d a=%h b=%h busy=%0d hi=%h lo=%h (MTLO during busy)", OP_MULTU, a, b, nb,
             bus.HI, bus.LO);
    n_cmp++;
    if ({nb, bus.HI, bus.LO} !== {lat, m_hi, m_lo}) begin
      $display("FAIL busy_ignore: busy=%0d hi=%h lo=%h want busy=%0d hi=%h lo=%h",
               nb, bus.HI, bus.LO, lat, m_hi, m_lo);
      n_bad++;
    end
  endtask

  task automatic test_reset_mid();
    int nb, lat;
    model_op(OP_MTHI, 32'd55, 32'd0, lat);
    run_op(OP_MTHI, 32'd55, 32'd0, nb);
    n_cmp++;
    if (bus.HI !== 32'd55) begin
      $display("FAIL mthi_before_reset: hi=%h want 00000037", bus.HI);
      n_bad++;
    end
    @(negedge clk);
    bus.Start = 1'b1; bus.MDUOp = OP_DIV; bus.A = 32'd100; bus.B = 32'd7;
    @(negedge clk);
    bus.Start = 1'b0;
    nb = 0;
    while (bus.Busy === 1'b1 && nb < 4) begin
      nb++;
      if (nb < 4) @(negedge clk);
    end
    #1 rst_n = 1'b0;
    #1;
    $display("op=%0d reset at busy cycle %0d: busy=%b hi=%h lo=%h", OP_DIV, nb, bus.Busy,
             bus.HI, bus.LO);
    m_hi = 32'd0; m_lo = 32'd0;
    n_cmp++;
    if ({nb, bus.Busy, bus.HI, bus.LO} !== {32'd4, 1'b0, 64'd0}) begin
      $display("FAIL reset_mid_op: cycles=%0d busy=%b hi=%h lo=%h want 4/0/0/0",
               nb, bus.Busy, bus.HI, bus.LO);
      n_bad++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    nb = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.Busy === 1'b1) nb++;
    end
    n_cmp++;
    if ({nb, bus.HI, bus.LO} !== {32'd0, 64'd0}) begin
      $display("FAIL reset_discard: busy_cycles=%0d hi=%h lo=%h want 0/0/0", nb, bus.HI, bus.LO);
      n_bad++;
    end
  endtask

  task automatic test_madd();
    int nb, lat;
    logic [31:0] want_lo;
    int          want_lat;
`ifdef MDU_MADD_EN
    want_lo = 32'd22; want_lat = ML;
`else
    want_lo = 32'd10; want_lat = 0;
`endif
    model_op(OP_MTHI, 32'd0, 32'd0, lat);
    run_op(OP_MTHI, 32'd0, 32'd0, nb);
    model_op(OP_MTLO, 32'd10, 32'd0, lat);
    run_op(OP_MTLO, 32'd10, 32'd0, nb);
    n_cmp++;
    if (bus.LO !== 32'd10) begin
      $display("FAIL mtlo: lo=%h want 0000000a", bus.LO);
      n_bad++;
    end
    model_op(OP_MADDU, 32'd3, 32'd4, lat);
    run_op(OP_MADDU, 32'd3, 32'd4, nb);
    n_cmp++;
    if ({nb, bus.HI, bus.LO} !== {want_lat, 32'd0, want_lo}) begin
      $display("FAIL maddu: busy=%0d hi=%h lo=%h want busy=%0d hi=0 lo=%h",
               nb, bus.HI, bus.LO, want_lat, want_lo);
      n_bad++;
    end
  endtask

  task automatic test_random();
    int nb, lat;
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      model_op(op, a, b, lat);
      run_op(op, a, b, nb);
      n_cmp++;
      if ({nb, bus.HI, bus.LO} !== {lat, m_hi, m_lo}) begin
        $display("FAIL random_%0d op=%0d a=%h b=%h: busy=%0d hi=%h lo=%h want busy=%0d hi=%h lo=%h",
                 i, op, a, b, nb, bus.HI, bus.LO, lat, m_hi, m_lo);
        n_bad++;
      end
    end
  endtask

  initial begin
    bus.Start = 1'b0; bus.MDUOp = OP_NOP; bus.A = 32'd0; bus.B = 32'd0;
    test_reset();
    test_directed();
    test_busy_ignore();
    test_reset_mid();
    test_madd();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_LAT, default 5: number of Busy cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_LAT, default 10: number of Busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Start  input  1  one-cycle request; MDUOp, A and B are valid with it.
REQ-006 SHALL have port MDUOp  input  4  operation code, encodings from mdu_pkg.
REQ-007 SHALL have port A  input  32  rs operand.
REQ-008 SHALL have port B  input  32  rt operand.
REQ-009 SHALL have port Busy  output  1  operation in progress.
REQ-010 SHALL have port HI  output  32  HI register.
REQ-011 SHALL have port LO  output  32  LO register.

Function
REQ-012 SHALL implement an FSM with states IDLE and BUSY and a down-counter cnt of width clog2(max(MULT_LAT,DIV_LAT)+1).
REQ-013 SHALL accept Start only in IDLE; Start in BUSY SHALL be ignored with no effect on state, operands or HI/LO.
REQ-014 SHALL, on an accepted MULT/MULTU/DIV/DIVU: latch A, B and MDUOp; enter BUSY at the next edge; load cnt with MULT_LAT or DIV_LAT.
REQ-015 SHALL assert Busy exactly when in BUSY, giving exactly LAT Busy cycles starting the cycle after Start.
REQ-016 SHALL decrement cnt each BUSY cycle; at cnt==1 it SHALL write the result to HI/LO and return to IDLE on the same edge, so the new HI/LO is visible in the first non-Busy cycle.
REQ-017 SHALL leave HI/LO unchanged while BUSY, until the completing edge.
REQ-018 MULT: {HI,LO} = signed 64-bit A*B. MULTU: unsigned 64-bit product.
REQ-019 DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of A. DIVU: unsigned quotient and remainder.
REQ-020 Divide by zero (B==0): HI = A and LO = 32'hFFFF_FFFF, for both signed and unsigned divide.
REQ-021 DIV with A=32'h8000_0000 and B=32'hFFFF_FFFF: LO = 32'h8000_0000, HI = 0.
REQ-022 MTHI/MTLO accepted in IDLE: write A to HI/LO at the next edge, 1-cycle latency, Busy stays low.
REQ-023 NOP, or any undefined MDUOp with Start: SHALL have no effect and SHALL not enter BUSY.
REQ-024 LAT parameters SHALL be >= 1.

Reset
REQ-025 SHALL, on rst_n low at any time (including mid-operation): go to IDLE, clear cnt, Busy=0, HI=0, LO=0, and clear the latched operands; the pending result SHALL be discarded.
REQ-026 SHALL ignore Start in the cycle rst_n deasserts if rst_n deasserts on that same edge, taking the first Start at the following edge.

Configuration
REQ-027 Macro MDU_MADD_EN: when defined, SHALL support MADD/MADDU/MSUB/MSUBU with latency MULT_LAT; {HI,LO} +/- the product, in 64-bit modulo arithmetic, signed or unsigned per op.
REQ-028 Without MDU_MADD_EN, those four encodings SHALL behave as undefined ops per REQ-023.

Structure
REQ-029 Package mdu_pkg SHALL hold the MDUOp encodings, the state enum and the default latency constants.
REQ-030 A combinational sub-module mdu_calc SHALL compute the 64-bit result from the latched operands and op; mdu_ctrl holds the FSM, counter and HI/LO.

Verification
REQ-031 MULT A=-3 (FFFF_FFFD), B=7 -> Busy high for exactly 5 cycles; then HI=FFFF_FFFF, LO=FFFF_FFEB.
REQ-032 DIVU A=100, B=7 -> Busy high for exactly 10 cycles; then LO=14, HI=2; DIV A=-7, B=2 -> LO=FFFF_FFFD, HI=FFFF_FFFF.
REQ-033 DIVU A=5, B=0 -> HI=5, LO=FFFF_FFFF; DIV 8000_0000/FFFF_FFFF -> LO=8000_0000, HI=0.
REQ-034 MULTU in flight, then Start MTLO A=1234 during Busy -> MTLO ignored; after completion LO equals the product's low word.
REQ-035 DIV started, rst_n pulsed low at Busy cycle 4 -> immediately Busy=0, HI=LO=0; no later HI/LO update.
REQ-036 With MDU_MADD_EN: MTHI 0, MTLO 10, then MADDU 3*4 -> LO=22, HI=0; without the macro, same sequence -> LO stays 10 and Busy never asserts.
